// File: rtl/cdm_seq_mul_pkg.sv
// Shared types and helpers for the nibble-serial
// carry-disregard multiplier.
package cdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

  function automatic int cd_level(
    input int   idx,
    input int   nib,
    input int   k_lo,
    input int   k_hi,
    input logic en
  );
    if (!en) return 0;
    return (idx < nib / 2) ? k_lo : k_hi;
  endfunction

endpackage

// File: rtl/cdm_seq_mul_if.sv
// Operand/product handshake bundle for cdm_seq_mul.
// master drives operands and consumes products.
interface cdm_seq_mul_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               approx_en;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] r;
  logic               busy;

  modport master (
    output in_valid, a, b, approx_en, out_ready,
    input  in_ready, out_valid, r, busy
  );

  modport slave (
    input  in_valid, a, b, approx_en, out_ready,
    output in_ready, out_valid, r, busy
  );
endinterface

// File: rtl/cdm_seq_mul_pp.sv
// WIDTH x 4 carry-disregard partial product: columns
// below k keep only their parity, the rest sum exactly.
module cd_nibble_pp #(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH + 4) + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [3:0]       b_nib,
  input  logic [KW-1:0]    k,
  output logic [WIDTH+3:0] pp
);
  localparam int C = WIDTH + 4;

  // a column holds at most four partial bits
  logic [2:0]   cnt [C];
  logic [C-1:0] lo;
  logic [C-1:0] hi;

  always_comb begin
    for (int c = 0; c < C; c++) begin
      cnt[c] = '0;
    end
    for (int j = 0; j < WIDTH; j++) begin
      for (int q = 0; q < 4; q++) begin
        cnt[j+q] = cnt[j+q]
                 + {2'b00, a[j] & b_nib[q]};
      end
    end
    lo = '0;
    hi = '0;
    for (int c = 0; c < C; c++) begin
      if (c < int'(k)) begin
        lo[c] = cnt[c][0];
      end else begin
        hi = hi
           + ({{(C-3){1'b0}}, cnt[c]} << c);
      end
    end
    pp = lo + hi;
  end

endmodule

// File: rtl/cdm_seq_mul.sv
// Nibble-serial carry-disregard multiplier: scans B one
// nibble per clock and accumulates partial products exactly.
module cdm_seq_mul
  import cdm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K_LO  = 7,
  parameter int K_HI  = 3
) (
  input logic         clk,
  input logic         rst,
  cdm_seq_mul_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int NW  = nib_w(NIB);
  localparam int KW  = $clog2(WIDTH + 4) + 1;
  localparam int AW  = 2 * WIDTH;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             en_q;
  logic [NW-1:0]    idx;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_nx;
  logic [AW-1:0]    r_q;
  logic [3:0]       b_nib;
  logic [KW-1:0]    k;
  logic [WIDTH+3:0] pp;
  logic             accept;
  logic             last;

  assign b_nib  = 4'(b_q >> {idx, 2'b00});
  assign k      = KW'(cd_level(int'(idx), NIB,
                               K_LO, K_HI, en_q));
  assign last   = (idx == NW'(NIB - 1));
  assign accept = bus.in_valid & bus.in_ready;
  assign acc_nx = acc
                + ({{(WIDTH-4){1'b0}}, pp}
                   << {idx, 2'b00});
  assign bus.r  = r_q;

  cd_nibble_pp #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_pp (
    .a     (a_q),
    .b_nib (b_nib),
    .k     (k),
    .pp    (pp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_nx = RUN;
      RUN:  if (last)         state_nx = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_nx = bus.in_valid ? RUN : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (1'b1)
      (state == IDLE): bus.in_ready = 1'b1;
      (state == RUN):  bus.busy     = 1'b1;
      (state == DONE): begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  // r is written only on the last RUN edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      en_q <= 1'b0;
      idx  <= '0;
      acc  <= '0;
      r_q  <= '0;
    end else if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      en_q <= bus.approx_en;
      idx  <= '0;
      acc  <= '0;
    end else if (state == RUN) begin
      acc <= acc_nx;
      idx <= idx + NW'(1);
      if (last) r_q <= acc_nx;
    end
  end

endmodule
